bcd_key_entry: RTL and testbench

- Upstream front end of the BCD entry path. Debounces the raw entry pushbutton and the sign switch.
- Sequences three digit captures from the 4-bit switch bus (ones, tens, hundreds).
- Presents a complete signed 3-digit BCD value with a one-cycle valid strobe. This feeds the BCD input, temperature-state and subtractor logic.
- Rejects non-BCD digits and aborts a partial entry when the sign mode changes.

---
 rtl/bcd_key_entry.sv | 187 ++++++++++++++++++
 tb/tb_bcd_key_entry.sv | 230 +++++++++++++++++++++++
 2 files changed

// File: rtl/bcd_key_entry.sv
// Debounced 3-digit signed BCD keypad entry: ones, tens, hundreds, then commit.
// Latency: raw key edge -> press after 2 + DEBOUNCE_CYCLES cycles; value_valid one cycle after the hundreds capture.
// Backpressure: none; strobes are single-cycle and must be consumed when they fire.
//
// Ports: clk/rst (sync, active-high); key_n, sign_sw raw asynchronous inputs;
// bcd_num digit switches; digit_idx next digit; ones/tens/huns_out + negative
// last committed value; value_valid / entry_err / entry_abort one-cycle strobes;
// sign_db debounced sign level.
// Optional macro BCD_KEY_ENTRY_RANGE_EN: reject committed values above 199.
module bcd_key_entry #(
    parameter int DEBOUNCE_CYCLES = 500000,
    parameter int CNT_W           = 20
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       key_n,
    input  logic       sign_sw,
    input  logic [3:0] bcd_num,
    output logic [1:0] digit_idx,
    output logic [3:0] ones_out,
    output logic [3:0] tens_out,
    output logic [3:0] huns_out,
    output logic       negative,
    output logic       value_valid,
    output logic       entry_err,
    output logic       entry_abort,
    output logic       sign_db
);

    localparam logic [CNT_W-1:0] DB_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

    typedef enum logic [1:0] {
        S_ONES   = 2'd0,
        S_TENS   = 2'd1,
        S_HUNS   = 2'd2,
        S_COMMIT = 2'd3
    } state_t;

    // Two-flop synchronizers; reset values match the idle debounced levels
    // so no spurious count starts after reset.
    logic key_s1, key_s2, sign_s1, sign_s2;

    always_ff @(posedge clk) begin
        if (rst) begin
            key_s1  <= 1'b1;
            key_s2  <= 1'b1;
            sign_s1 <= 1'b0;
            sign_s2 <= 1'b0;
        end else begin
            key_s1  <= key_n;
            key_s2  <= key_s1;
            sign_s1 <= sign_sw;
            sign_s2 <= sign_s1;
        end
    end

    // Debounce: the level flips only after DEBOUNCE_CYCLES consecutive
    // samples disagreeing with it.
    logic [CNT_W-1:0] key_cnt, sign_cnt;
    logic             key_db, key_db_d1, sign_db_d1;

    always_ff @(posedge clk) begin
        if (rst) begin
            key_cnt    <= '0;
            sign_cnt   <= '0;
            key_db     <= 1'b1;
            key_db_d1  <= 1'b1;
            sign_db    <= 1'b0;
            sign_db_d1 <= 1'b0;
        end else begin
            key_db_d1  <= key_db;
            sign_db_d1 <= sign_db;

            if (key_s2 == key_db) begin
                key_cnt <= '0;
            end else if (key_cnt == DB_LAST) begin
                key_db  <= ~key_db;
                key_cnt <= '0;
            end else begin
                key_cnt <= key_cnt + 1'b1;
            end

            if (sign_s2 == sign_db) begin
                sign_cnt <= '0;
            end else if (sign_cnt == DB_LAST) begin
                sign_db  <= ~sign_db;
                sign_cnt <= '0;
            end else begin
                sign_cnt <= sign_cnt + 1'b1;
            end
        end
    end

    // Press on debounced falling edge only; sign change on either edge.
    logic press, sign_chg;
    assign press    = key_db_d1 & ~key_db;
    assign sign_chg = sign_db_d1 ^ sign_db;

    state_t     state;
    logic [3:0] sh_ones, sh_tens, sh_huns;
    logic       sh_neg;

    always_ff @(posedge clk) begin
        if (rst) begin
            state       <= S_ONES;
            digit_idx   <= 2'd0;
            sh_ones     <= '0;
            sh_tens     <= '0;
            sh_huns     <= '0;
            sh_neg      <= 1'b0;
            ones_out    <= '0;
            tens_out    <= '0;
            huns_out    <= '0;
            negative    <= 1'b0;
            value_valid <= 1'b0;
            entry_err   <= 1'b0;
            entry_abort <= 1'b0;
        end else begin
            value_valid <= 1'b0;
            entry_err   <= 1'b0;
            entry_abort <= 1'b0;
            case (state)
                S_ONES: begin
                    // A sign change with nothing captured yet is harmless.
                    if (press) begin
                        if (bcd_num > 4'd9) begin
                            entry_err <= 1'b1;
                        end else begin
                            sh_ones   <= bcd_num;
                            state     <= S_TENS;
                            digit_idx <= 2'd1;
                        end
                    end
                end
                S_TENS, S_HUNS: begin
                    // Abort beats a simultaneous press: the digit is dropped.
                    if (sign_chg) begin
                        sh_ones     <= '0;
                        sh_tens     <= '0;
                        sh_huns     <= '0;
                        sh_neg      <= 1'b0;
                        entry_abort <= 1'b1;
                        state       <= S_ONES;
                        digit_idx   <= 2'd0;
                    end else if (press) begin
                        if (bcd_num > 4'd9) begin
                            entry_err <= 1'b1;
                        end else if (state == S_TENS) begin
                            sh_tens   <= bcd_num;
                            state     <= S_HUNS;
                            digit_idx <= 2'd2;
                        end else begin
                            sh_huns   <= bcd_num;
                            sh_neg    <= sign_db;
                            state     <= S_COMMIT;
                            digit_idx <= 2'd0;
                        end
                    end
                end
                default: begin
                    // S_COMMIT lasts one cycle; presses are too far apart
                    // to land here.
`ifdef BCD_KEY_ENTRY_RANGE_EN
                    if (sh_huns > 4'd1) begin
                        entry_err <= 1'b1;
                    end else begin
                        ones_out    <= sh_ones;
                        tens_out    <= sh_tens;
                        huns_out    <= sh_huns;
                        negative    <= sh_neg;
                        value_valid <= 1'b1;
                    end
`else
                    ones_out    <= sh_ones;
                    tens_out    <= sh_tens;
                    huns_out    <= sh_huns;
                    negative    <= sh_neg;
                    value_valid <= 1'b1;
`endif
                    state     <= S_ONES;
                    digit_idx <= 2'd0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_bcd_key_entry.sv
// Directed bench for bcd_key_entry with a small debounce window.
// Expected strobes are queued as stimulus is driven and matched by a monitor.
// Outputs are sampled away from the rising edge.
module tb_bcd_key_entry;

    logic       clk = 1'b0;
    logic       rst;
    logic       key_n;
    logic       sign_sw;
    logic [3:0] bcd_num;
    logic [1:0] digit_idx;
    logic [3:0] ones_out, tens_out, huns_out;
    logic       negative, value_valid, entry_err, entry_abort, sign_db;

    always #5 clk = ~clk;

    bcd_key_entry #(.DEBOUNCE_CYCLES(4), .CNT_W(3)) dut (
        .clk        (clk),
        .rst        (rst),
        .key_n      (key_n),
        .sign_sw    (sign_sw),
        .bcd_num    (bcd_num),
        .digit_idx  (digit_idx),
        .ones_out   (ones_out),
        .tens_out   (tens_out),
        .huns_out   (huns_out),
        .negative   (negative),
        .value_valid(value_valid),
        .entry_err  (entry_err),
        .entry_abort(entry_abort),
        .sign_db    (sign_db)
    );

    // kind: 0 = value_valid, 1 = entry_err, 2 = entry_abort
    typedef struct {
        int         kind;
        logic [3:0] h;
        logic [3:0] t;
        logic [3:0] o;
        logic       neg;
    } ev_t;

    ev_t exp_q[$];
    int  checks = 0;
    int  errors = 0;

    // Model of the last committed value.
    logic [3:0] cur_h = 4'd0, cur_t = 4'd0, cur_o = 4'd0;
    logic       cur_neg = 1'b0;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] expv);
        checks++;
        assert (obs === expv) else begin
            errors++;
            $error("FAIL %s observed %0h expected %0h", tag, obs, expv);
        end
    endtask

    task automatic push_err();
        ev_t e;
        e = '{1, cur_h, cur_t, cur_o, cur_neg};
        exp_q.push_back(e);
    endtask

    task automatic push_abort();
        ev_t e;
        e = '{2, cur_h, cur_t, cur_o, cur_neg};
        exp_q.push_back(e);
    endtask

    task automatic push_commit(input logic [3:0] h, input logic [3:0] t,
                               input logic [3:0] o, input logic n);
        ev_t e;
`ifdef BCD_KEY_ENTRY_RANGE_EN
        if (h > 4'd1) begin
            push_err();
            return;
        end
`endif
        e = '{0, h, t, o, n};
        exp_q.push_back(e);
        cur_h = h; cur_t = t; cur_o = o; cur_neg = n;
    endtask

    // Monitor: every strobe must match the head of the queue.
    always @(negedge clk) begin
        if (rst === 1'b0) begin
            int n;
            int kind;
            ev_t e;
            n = int'(value_valid) + int'(entry_err) + int'(entry_abort);
            if (n > 1) check("strobe_exclusive", 32'(n), 32'd1);
            else if (n == 1) begin
                kind = value_valid ? 0 : (entry_err ? 1 : 2);
                if (exp_q.size() == 0) begin
                    check("unexpected_event", 32'(kind), 32'hFF);
                end else begin
                    e = exp_q.pop_front();
                    check("event_kind", 32'(kind), 32'(e.kind));
                    check("event_value", {19'd0, negative, huns_out, tens_out, ones_out},
                          {19'd0, e.neg, e.h, e.t, e.o});
                end
            end
        end
    end

    task automatic cycles(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    // Clean press and release, each held well past the debounce window.
    task automatic press_digit(input logic [3:0] d);
        @(negedge clk);
        bcd_num = d;
        key_n   = 1'b0;
        cycles(10);
        @(negedge clk);
        key_n = 1'b1;
        cycles(10);
    endtask

    initial begin
        rst = 1'b1; key_n = 1'b1; sign_sw = 1'b0; bcd_num = 4'd0;
        cycles(3);
        check("rst_digit_idx", 32'(digit_idx), 32'd0);
        check("rst_value", {20'd0, huns_out, tens_out, ones_out}, 32'd0);
        check("rst_negative", 32'(negative), 32'd0);
        check("rst_strobes", {29'd0, value_valid, entry_err, entry_abort}, 32'd0);
        check("rst_sign_db", 32'(sign_db), 32'd0);
        @(negedge clk);
        rst = 1'b0;
        cycles(2);

        // 7, 4, 1 positive -> 147
        press_digit(4'd7);
        check("idx_after_ones", 32'(digit_idx), 32'd1);
        press_digit(4'd4);
        check("idx_after_tens", 32'(digit_idx), 32'd2);
        push_commit(4'd1, 4'd4, 4'd7, 1'b0);
        press_digit(4'd1);
        check("idx_after_commit", 32'(digit_idx), 32'd0);

        // Three-cycle glitch must not register.
        @(negedge clk);
        bcd_num = 4'd5;
        key_n   = 1'b0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        key_n = 1'b1;
        cycles(12);
        check("glitch_idx", 32'(digit_idx), 32'd0);

        // Latency: capture on the 7th edge after the raw edge is first sampled.
        @(negedge clk);
        bcd_num = 4'd2;
        key_n   = 1'b0;
        cycles(6);
        check("latency_before", 32'(digit_idx), 32'd0);
        cycles(1);
        check("latency_at", 32'(digit_idx), 32'd1);
        cycles(3);
        @(negedge clk);
        key_n = 1'b1;
        cycles(10);

        // Non-BCD digit in TENS is rejected, then 3 and 2 complete 232.
        push_err();
        press_digit(4'd12);
        check("err_idx_hold", 32'(digit_idx), 32'd1);
        press_digit(4'd3);
        push_commit(4'd2, 4'd3, 4'd2, 1'b0);
        press_digit(4'd2);
        check("idx_after_232", 32'(digit_idx), 32'd0);

        // Sign change in HUNS aborts; then 0,0,1 negative -> -100.
        press_digit(4'd5);
        press_digit(4'd5);
        check("idx_before_abort", 32'(digit_idx), 32'd2);
        push_abort();
        @(negedge clk);
        sign_sw = 1'b1;
        cycles(12);
        check("abort_idx", 32'(digit_idx), 32'd0);
        check("sign_db_high", 32'(sign_db), 32'd1);
        press_digit(4'd0);
        press_digit(4'd0);
        push_commit(4'd1, 4'd0, 4'd0, 1'b1);
        press_digit(4'd1);

        // Reset mid-entry clears everything.
        press_digit(4'd9);
        press_digit(4'd9);
        check("idx_before_rst", 32'(digit_idx), 32'd2);
        @(negedge clk);
        rst = 1'b1;
        cycles(1);
        check("midrst_idx", 32'(digit_idx), 32'd0);
        check("midrst_value", {19'd0, negative, huns_out, tens_out, ones_out}, 32'd0);
        check("midrst_sign_db", 32'(sign_db), 32'd0);
        cur_h = 4'd0; cur_t = 4'd0; cur_o = 4'd0; cur_neg = 1'b0;
        @(negedge clk);
        rst = 1'b0;
        cycles(12);
        check("sign_db_resettled", 32'(sign_db), 32'd1);

        // 9,9,9 negative: committed, or rejected when range check is built in.
        press_digit(4'd9);
        press_digit(4'd9);
        push_commit(4'd9, 4'd9, 4'd9, 1'b1);
        press_digit(4'd9);
        check("idx_after_999", 32'(digit_idx), 32'd0);

        // Long hold gives exactly one capture; release gives nothing.
        @(negedge clk);
        bcd_num = 4'd3;
        key_n   = 1'b0;
        cycles(50);
        check("hold_idx", 32'(digit_idx), 32'd1);
        @(negedge clk);
        key_n = 1'b1;
        cycles(15);
        check("release_idx", 32'(digit_idx), 32'd1);

        check("queue_drained", 32'(exp_q.size()), 32'd0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
